// File: rtl/controle_sirene.sv
// Siren controller for an intrusion alarm: arm/disarm, entry delay with a
// blinking warning LED, timed siren period and a saturating activation count.
module controle_sirene #(
    parameter int ATRASO       = 10,
    parameter int TEMPO_SIRENE = 50
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       ALARME,
    input  logic       SISTEMA,
    output logic       SIRENE,
    output logic       PISCA,
    output logic [1:0] ESTADO,
    output logic [3:0] DISPAROS
);

    typedef enum logic [1:0] {
        S_DESARMADO = 2'b00,
        S_VIGIA     = 2'b01,
        S_CONTAGEM  = 2'b10,
        S_SIRENE    = 2'b11
    } estado_t;

    // Last counter value of each timed state; the state lasts value+1 cycles.
    localparam logic [7:0] FIM_CONTAGEM = 8'(ATRASO - 1);
    localparam logic [7:0] FIM_SIRENE   = 8'(TEMPO_SIRENE - 1);

    estado_t    r_estado;
    estado_t    w_proximo;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_prox;
    logic       r_sirene;
    logic       w_sirene_prox;
    logic       r_pisca;
    logic       w_pisca_prox;
    logic [3:0] r_disparos;
    logic [3:0] w_disparos_prox;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_estado   <= S_DESARMADO;
            r_cnt      <= 8'd0;
            r_sirene   <= 1'b0;
            r_pisca    <= 1'b0;
            r_disparos <= 4'd0;
        end else begin
            r_estado   <= w_proximo;
            r_cnt      <= w_cnt_prox;
            r_sirene   <= w_sirene_prox;
            r_pisca    <= w_pisca_prox;
            r_disparos <= w_disparos_prox;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            S_DESARMADO: w_proximo = S_VIGIA;
            S_VIGIA: begin
                if (ALARME) w_proximo = S_CONTAGEM;
            end
            S_CONTAGEM: begin
                if (r_cnt == FIM_CONTAGEM) w_proximo = S_SIRENE;
            end
            S_SIRENE: begin
                if (r_cnt == FIM_SIRENE) w_proximo = S_VIGIA;
            end
            default: w_proximo = S_DESARMADO;
        endcase
        // Disarm overrides every other transition, including aborting a siren.
        if (!SISTEMA) w_proximo = S_DESARMADO;
    end

    always_comb begin
        w_cnt_prox = r_cnt;
        if (w_proximo != r_estado) begin
            w_cnt_prox = 8'd0;
        end else if ((r_estado == S_CONTAGEM) || (r_estado == S_SIRENE)) begin
            w_cnt_prox = r_cnt + 8'd1;
        end
    end

    // Outputs are computed from the next state so they line up with ESTADO.
    always_comb begin
        w_sirene_prox = (w_proximo == S_SIRENE);
        w_pisca_prox  = 1'b0;
        if (w_proximo == S_CONTAGEM) begin
            w_pisca_prox = (r_estado != S_CONTAGEM) ? 1'b1 : ~r_pisca;
        end
    end

    always_comb begin
        w_disparos_prox = r_disparos;
        if ((w_proximo == S_SIRENE) && (r_estado != S_SIRENE) && (r_disparos != 4'hF)) begin
            w_disparos_prox = r_disparos + 4'd1;
        end
    end

    assign ESTADO   = r_estado;
    assign SIRENE   = r_sirene;
    assign PISCA    = r_pisca;
    assign DISPAROS = r_disparos;

endmodule

// File: tb/tb_controle_sirene.sv
// Directed bench for controle_sirene with ATRASO=4, TEMPO_SIRENE=6.
module tb_controle_sirene;

    logic       CLK;
    logic       RST_N;
    logic       ALARME;
    logic       SISTEMA;
    logic       SIRENE;
    logic       PISCA;
    logic [1:0] ESTADO;
    logic [3:0] DISPAROS;

    int n_checks;
    int n_errors;

    controle_sirene #(
        .ATRASO      (4),
        .TEMPO_SIRENE(6)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .ALARME  (ALARME),
        .SISTEMA (SISTEMA),
        .SIRENE  (SIRENE),
        .PISCA   (PISCA),
        .ESTADO  (ESTADO),
        .DISPAROS(DISPAROS)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance one rising edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N   = 1'b0;
        ALARME  = 1'b0;
        SISTEMA = 1'b0;
        step();
        step();
        RST_N = 1'b1;
    endtask

    task automatic arm();
        SISTEMA = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RST_N   = 1'b0;
        ALARME  = 1'b1;
        SISTEMA = 1'b1;
        #2;
        n_checks++;
        if (ESTADO !== 2'b00 || SIRENE !== 1'b0 || PISCA !== 1'b0 || DISPAROS !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_values: ESTADO=%b SIRENE=%b PISCA=%b DISPAROS=%0d expected 00 0 0 0",
                     ESTADO, SIRENE, PISCA, DISPAROS);
        end
        step();
        step();
        n_checks++;
        if (ESTADO !== 2'b00 || SIRENE !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: ESTADO=%b SIRENE=%b expected 00 0", ESTADO, SIRENE);
        end
        RST_N = 1'b1;
        step();
        n_checks++;
        if (ESTADO !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_first_edge: ESTADO=%b expected 01", ESTADO);
        end
    endtask

    task automatic test_arm_trigger();
        do_reset();
        arm();
        n_checks++;
        if (ESTADO !== 2'b01 || SIRENE !== 1'b0 || PISCA !== 1'b0) begin
            n_errors++;
            $display("FAIL arm_vigia: ESTADO=%b SIRENE=%b PISCA=%b expected 01 0 0", ESTADO, SIRENE, PISCA);
        end
        ALARME = 1'b1;
        step();
        ALARME = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ESTADO !== 2'b10 || PISCA !== ((i % 2) == 0) || SIRENE !== 1'b0) begin
                n_errors++;
                $display("FAIL contagem_cycle%0d: ESTADO=%b PISCA=%b SIRENE=%b expected 10 %0d 0",
                         i, ESTADO, PISCA, SIRENE, (i % 2) == 0);
            end
            step();
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ESTADO !== 2'b11 || SIRENE !== 1'b1 || PISCA !== 1'b0 || DISPAROS !== 4'd1) begin
                n_errors++;
                $display("FAIL sirene_cycle%0d: ESTADO=%b SIRENE=%b PISCA=%b DISPAROS=%0d expected 11 1 0 1",
                         i, ESTADO, SIRENE, PISCA, DISPAROS);
            end
            step();
        end
        n_checks++;
        if (ESTADO !== 2'b01 || SIRENE !== 1'b0 || DISPAROS !== 4'd1) begin
            n_errors++;
            $display("FAIL back_to_vigia: ESTADO=%b SIRENE=%b DISPAROS=%0d expected 01 0 1",
                     ESTADO, SIRENE, DISPAROS);
        end
    endtask

    task automatic test_disarm_abort();
        do_reset();
        arm();
        ALARME = 1'b1;
        step();
        ALARME = 1'b0;
        repeat (4) step();
        step();
        step();
        n_checks++;
        if (ESTADO !== 2'b11 || SIRENE !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_setup: ESTADO=%b SIRENE=%b expected 11 1", ESTADO, SIRENE);
        end
        SISTEMA = 1'b0;
        step();
        n_checks++;
        if (ESTADO !== 2'b00 || SIRENE !== 1'b0 || PISCA !== 1'b0 || DISPAROS !== 4'd1) begin
            n_errors++;
            $display("FAIL disarm_abort: ESTADO=%b SIRENE=%b PISCA=%b DISPAROS=%0d expected 00 0 0 1",
                     ESTADO, SIRENE, PISCA, DISPAROS);
        end
    endtask

    task automatic test_persistent_alarm();
        int exp_disp;
        do_reset();
        arm();
        ALARME = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            exp_disp = (k > 15) ? 15 : k;
            n_checks++;
            if (ESTADO !== 2'b01) begin
                n_errors++;
                $display("FAIL persist_vigia%0d: ESTADO=%b expected 01", k, ESTADO);
            end
            step();
            n_checks++;
            if (ESTADO !== 2'b10 || PISCA !== 1'b1) begin
                n_errors++;
                $display("FAIL persist_contagem%0d: ESTADO=%b PISCA=%b expected 10 1", k, ESTADO, PISCA);
            end
            repeat (4) step();
            n_checks++;
            if (ESTADO !== 2'b11 || DISPAROS !== 4'(exp_disp)) begin
                n_errors++;
                $display("FAIL persist_disparos%0d: ESTADO=%b DISPAROS=%0d expected 11 %0d",
                         k, ESTADO, DISPAROS, exp_disp);
            end
            repeat (6) step();
        end
        ALARME = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        arm();
        ALARME = 1'b1;
        step();
        ALARME = 1'b0;
        repeat (4) step();
        step();
        #2;
        RST_N = 1'b0;
        #1;
        n_checks++;
        if (SIRENE !== 1'b0 || ESTADO !== 2'b00 || DISPAROS !== 4'd0 || PISCA !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: SIRENE=%b ESTADO=%b DISPAROS=%0d PISCA=%b expected 0 00 0 0",
                     SIRENE, ESTADO, DISPAROS, PISCA);
        end
        #2;
        RST_N = 1'b1;
        step();
        n_checks++;
        if (ESTADO !== 2'b01 || SIRENE !== 1'b0) begin
            n_errors++;
            $display("FAIL after_async_reset: ESTADO=%b SIRENE=%b expected 01 0", ESTADO, SIRENE);
        end
    endtask

    task automatic test_disarmed_ignore();
        int bad;
        do_reset();
        SISTEMA = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            ALARME = i[0];
            step();
            if (ESTADO !== 2'b00 || SIRENE !== 1'b0) bad++;
        end
        ALARME = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL disarmed_ignore: %0d bad cycles expected 0 (last ESTADO=%b SIRENE=%b)",
                     bad, ESTADO, SIRENE);
        end
    endtask

    task automatic test_simultaneous();
        int sir_seen;
        do_reset();
        arm();
        ALARME = 1'b1;
        step();
        ALARME = 1'b0;
        repeat (3) step();
        n_checks++;
        if (ESTADO !== 2'b10 || PISCA !== 1'b0) begin
            n_errors++;
            $display("FAIL simult_setup: ESTADO=%b PISCA=%b expected 10 0", ESTADO, PISCA);
        end
        SISTEMA = 1'b0;
        sir_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (SIRENE !== 1'b0) sir_seen++;
        end
        n_checks++;
        if (ESTADO !== 2'b00 || sir_seen != 0 || DISPAROS !== 4'd0 || PISCA !== 1'b0) begin
            n_errors++;
            $display("FAIL simultaneous: ESTADO=%b siren_cycles=%0d DISPAROS=%0d PISCA=%b expected 00 0 0 0",
                     ESTADO, sir_seen, DISPAROS, PISCA);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST_N    = 1'b0;
        ALARME   = 1'b0;
        SISTEMA  = 1'b0;
        test_reset();
        test_arm_trigger();
        test_disarm_abort();
        test_persistent_alarm();
        test_async_reset();
        test_disarmed_ignore();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controle_sirene.md
CONTROLE_SIRENE -- requirements
Module: controle_sirene

Interface
REQ-001 The block SHALL have parameter ATRASO, default 10, giving the entry-delay length in clock cycles (legal range 1..255).
REQ-002 The block SHALL have parameter TEMPO_SIRENE, default 50, giving the siren-on length in clock cycles (legal range 1..255).
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 ALARME  input  1  alarm request from the upstream alarm-logic stage, sampled at CLK.
REQ-006 SISTEMA  input  1  arm switch; 1 = armed, 0 = disarmed.
REQ-007 SIRENE  output  1  siren drive, registered.
REQ-008 PISCA  output  1  warning LED, toggling during entry delay, registered.
REQ-009 ESTADO  output  2  current state code, registered.
REQ-010 DISPAROS  output  4  count of siren activations since reset, saturating.

Function
REQ-011 The block SHALL implement four states: DESARMADO (00), VIGIA (01), CONTAGEM (10), SIRENE (11); ESTADO SHALL always equal the current state code.
REQ-012 SISTEMA=0 at a rising edge SHALL move any state to DESARMADO on that edge, with highest priority over all other transitions.
REQ-013 DESARMADO SHALL move to VIGIA on the first edge with SISTEMA=1; ALARME is ignored in DESARMADO and on that edge.
REQ-014 VIGIA SHALL move to CONTAGEM on an edge with SISTEMA=1 and ALARME=1, and otherwise SHALL stay in VIGIA.
REQ-015 CONTAGEM SHALL last exactly ATRASO cycles and then move to SIRENE, independent of ALARME (deasserting ALARME does not cancel the delay).
REQ-016 SIRENE SHALL last exactly TEMPO_SIRENE cycles and then move to VIGIA.
REQ-017 If ALARME is still 1 in VIGIA after a siren period, the block SHALL retrigger a new CONTAGEM per REQ-014.
REQ-018 An 8-bit internal cycle counter SHALL be cleared on every state change and SHALL increment each cycle within CONTAGEM and SIRENE.
REQ-019 SIRENE output SHALL be 1 exactly in cycles where ESTADO=11, and 0 otherwise.
REQ-020 PISCA SHALL be 0 outside CONTAGEM.
REQ-021 PISCA SHALL be 1 in the first CONTAGEM cycle and SHALL invert every subsequent cycle of CONTAGEM.
REQ-022 DISPAROS SHALL increment by 1 on each transition into SIRENE, SHALL saturate at 15, and SHALL be cleared only by reset.
REQ-023 Disarming does not clear DISPAROS.
REQ-024 A disarm during CONTAGEM or SIRENE SHALL abort the sequence immediately: SIRENE=0 and PISCA=0 from the next edge.
REQ-025 Latency from ALARME=1 sampled in VIGIA to SIRENE=1 SHALL be exactly ATRASO+1 rising edges.

Reset
REQ-026 RST_N=0 SHALL immediately, without waiting for CLK, force state DESARMADO: ESTADO=00, SIRENE=0, PISCA=0, DISPAROS=0, and the internal counter to 0.
REQ-027 Outputs SHALL hold their reset values while RST_N=0.
REQ-028 After RST_N rises, the first transition SHALL occur on the next CLK edge, following REQ-013.
REQ-029 Reset asserted mid-CONTAGEM or mid-SIRENE SHALL abort the sequence with no residual siren pulse.

Verification (ATRASO=4, TEMPO_SIRENE=6)
REQ-030 Arm-and-trigger: reset; SISTEMA=1 for 1 edge -> ESTADO=01.
- ALARME=1 for 1 cycle -> ESTADO=10 for 4 cycles, with PISCA=1,0,1,0.
- Then SIRENE=1 for 6 cycles, DISPAROS=1.
- Then ESTADO=01.
REQ-031 Abort by disarm: trigger, then SISTEMA=0 in the 3rd SIRENE cycle -> next edge ESTADO=00, SIRENE=0, DISPAROS stays 1.
REQ-032 Persistent alarm: ALARME held at 1 -> sequence repeats with CONTAGEM immediately after each VIGIA cycle.
- DISPAROS counts 1, 2, 3, ... and saturates at 15 after 15 or more cycles.
REQ-033 Async reset: RST_N=0 pulsed between CLK edges during SIRENE -> SIRENE, ESTADO and DISPAROS go to 0 before the next edge.
REQ-034 Ignore when disarmed: SISTEMA=0, ALARME toggling for 20 cycles -> ESTADO=00, SIRENE=0 throughout.
REQ-035 Simultaneous events: SISTEMA falls on the same edge CONTAGEM would enter SIRENE -> ESTADO=00, SIRENE never 1, DISPAROS unchanged.
